change_dispenser: RTL and testbench

//  Pays out the change owed after a sale or cancel, one coin at a time, greedy largest-denomination-first.
//  The controller pulses start with the amount owed; the block drives one-hot eject requests to the coin

---
 rtl/vend_pkg.sv | 57 +++++
 rtl/dispense_timer.sv | 35 +++
 rtl/change_dispenser.sv | 177 +++++++++++++++++
 tb/tb_change_dispenser.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin-denomination definitions and FSM state encodings for the change dispenser.
package vend_pkg;

    localparam int NUM_DENOM = 4;

    localparam logic [1:0] DENOM_HALF = 2'd0;
    localparam logic [1:0] DENOM_ONE  = 2'd1;
    localparam logic [1:0] DENOM_FIVE = 2'd2;
    localparam logic [1:0] DENOM_TEN  = 2'd3;

    localparam logic [4:0] VALUE_HALF = 5'd1;
    localparam logic [4:0] VALUE_ONE  = 5'd2;
    localparam logic [4:0] VALUE_FIVE = 5'd10;
    localparam logic [4:0] VALUE_TEN  = 5'd20;

    localparam logic [3:0] EJECT_HALF = 4'b0001;
    localparam logic [3:0] EJECT_ONE  = 4'b0010;
    localparam logic [3:0] EJECT_FIVE = 4'b0100;
    localparam logic [3:0] EJECT_TEN  = 4'b1000;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_SELECT = 3'd1;
    localparam logic [2:0] ENC_EJECT  = 3'd2;
    localparam logic [2:0] ENC_GAP    = 3'd3;
    localparam logic [2:0] ENC_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SELECT = ENC_SELECT,
        ST_EJECT  = ENC_EJECT,
        ST_GAP    = ENC_GAP,
        ST_DONE   = ENC_DONE
    } state_t;

    function automatic logic [4:0] coin_value(input logic [1:0] idx);
        logic [4:0] val;
        case (idx)
            DENOM_HALF: val = VALUE_HALF;
            DENOM_ONE:  val = VALUE_ONE;
            DENOM_FIVE: val = VALUE_FIVE;
            default:    val = VALUE_TEN;
        endcase
        return val;
    endfunction

    function automatic logic [3:0] coin_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            DENOM_HALF: oh = EJECT_HALF;
            DENOM_ONE:  oh = EJECT_ONE;
            DENOM_FIVE: oh = EJECT_FIVE;
            default:    oh = EJECT_TEN;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Shared down-counter used for both the post-ack gap and the hopper ack timeout.
// Loading N-1 makes expired rise on the Nth cycle after the load edge.
module dispense_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout controller driving a one-hot hopper eject interface.
// Optional units-paid counter enabled by defining CHANGE_DISPENSER_TALLY_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int W              = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] amount,
    input  logic [3:0]   tube_empty,
    input  logic         hopper_ack,
    output logic [3:0]   eject,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] short_amt,
    output logic         fault
`ifdef CHANGE_DISPENSER_TALLY_EN
    ,
    output logic [15:0]  tally
`endif
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [1:0]     den_q, den_d;
    logic [3:0]     eject_q, eject_d;
    logic [W-1:0]   short_q, short_d;
    logic           fault_q, fault_d;

    logic             sel_valid;
    logic [1:0]       sel_idx;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    // Ascending scan so the largest eligible denomination wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = DENOM_HALF;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (!tube_empty[i] && (W'(coin_value(2'(i))) <= rem_q)) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        den_d    = den_q;
        eject_d  = eject_q;
        short_d  = short_q;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                eject_d = 4'b0000;
                if (start) begin
                    rem_d   = amount;
                    fault_d = 1'b0;
                    short_d = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (!sel_valid) begin
                    short_d = rem_q;
                    state_d = ST_DONE;
                end else begin
                    eject_d  = coin_onehot(sel_idx);
                    den_d    = sel_idx;
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
                    state_d  = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (hopper_ack) begin
                    rem_d    = rem_q - W'(coin_value(den_q));
                    eject_d  = 4'b0000;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = ST_GAP;
                end else if (tmr_expired) begin
                    eject_d = 4'b0000;
                    fault_d = 1'b1;
                    short_d = rem_q;
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                eject_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            den_q   <= DENOM_HALF;
            eject_q <= 4'b0000;
            short_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            eject_q <= eject_d;
            short_q <= short_d;
            fault_q <= fault_d;
        end
    end

    dispense_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

`ifdef CHANGE_DISPENSER_TALLY_EN
    logic [15:0] tally_q, tally_d;
    logic [16:0] tally_sum;

    // Saturating count of units released, bumped on every accepted ack.
    always_comb begin
        tally_sum = {1'b0, tally_q} + 17'(coin_value(den_q));
        tally_d   = tally_q;
        if (state_q == ST_EJECT && hopper_ack) begin
            tally_d = tally_sum[16] ? 16'hFFFF : tally_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tally_q <= '0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign tally = tally_q;
`endif

    assign eject     = eject_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign short_amt = short_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (timeout shortened to 16 cycles).
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] amount;
    logic [3:0] tube_empty;
    logic       hopper_ack;
    logic [3:0] eject;
    logic       busy;
    logic       done;
    logic [7:0] short_amt;
    logic       fault;

    int compared;
    int mismatched;

    logic [3:0] ejectLog[$];
    bit         doneSeen;
    bit         unstable;
    int         maxRun;
    logic [7:0] lastShort;
    logic       lastFault;

    change_dispenser #(
        .W              (8),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .tube_empty (tube_empty),
        .hopper_ack (hopper_ack),
        .eject      (eject),
        .busy       (busy),
        .done       (done),
        .short_amt  (short_amt),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one payout, acking 3 sampled cycles after each eject rises; logs eject order.
    task automatic payout(input logic [7:0] amt, input logic [3:0] empties,
                          input bit ackOn, input int extraStartCycle);
        int run;
        logic [3:0] prevEject;
        ejectLog.delete();
        doneSeen  = 0;
        unstable  = 0;
        maxRun    = 0;
        run       = 0;
        prevEject = 4'b0000;
        lastShort = 8'hxx;
        lastFault = 1'bx;
        @(negedge clk);
        start      = 1'b1;
        amount     = amt;
        tube_empty = empties;
        hopper_ack = 1'b0;
        for (int cyc = 0; cyc < 3000 && !doneSeen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == extraStartCycle) begin
                start  = 1'b1;
                amount = 8'd5;
            end
            if (eject !== 4'b0000) begin
                if (prevEject === 4'b0000) ejectLog.push_back(eject);
                else if (eject !== prevEject) unstable = 1;
                run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
            prevEject  = eject;
            hopper_ack = ackOn && (run == 3);
            if (done === 1'b1) begin
                doneSeen  = 1;
                lastShort = short_amt;
                lastFault = fault;
            end
        end
        start      = 1'b0;
        hopper_ack = 1'b0;
    endtask

    task automatic test_reset();
        compared++;
        if ({eject, busy, done, short_amt, fault} !== 15'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got eject=%b busy=%b done=%b short=%0d fault=%b expected all zero",
                     eject, busy, done, short_amt, fault);
        end
    endtask

    task automatic test_greedy_37();
        logic [3:0] exp[6];
        exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        payout(8'd37, 4'b0000, 1'b1, -1);
        compared++;
        if (doneSeen !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL g37_done: got %b expected 1", doneSeen);
        end
        compared++;
        if (ejectLog.size() != 6) begin
            mismatched++;
            $display("[TB] FAIL g37_count: got %0d expected 6", ejectLog.size());
        end
        for (int i = 0; i < 6 && i < ejectLog.size(); i++) begin
            compared++;
            if (ejectLog[i] !== exp[i]) begin
                mismatched++;
                $display("[TB] FAIL g37_coin%0d: got %b expected %b", i, ejectLog[i], exp[i]);
            end
        end
        compared++;
        if (lastShort !== 8'd0 || lastFault !== 1'b0 || unstable) begin
            mismatched++;
            $display("[TB] FAIL g37_status: got short=%0d fault=%b unstable=%b expected 0/0/0",
                     lastShort, lastFault, unstable);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL g37_done_pulse: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_empty_ten();
        payout(8'd20, 4'b1000, 1'b1, -1);
        compared++;
        if (ejectLog.size() != 2 || ejectLog[0] !== 4'b0100 || ejectLog[1] !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL e10_coins: got count=%0d expected two 0100 ejects", ejectLog.size());
        end
        compared++;
        if (doneSeen !== 1'b1 || lastShort !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL e10_short: got done=%b short=%0d expected 1/0", doneSeen, lastShort);
        end
    endtask

    task automatic test_shortfall();
        payout(8'd3, 4'b0001, 1'b1, -1);
        compared++;
        if (ejectLog.size() != 1 || ejectLog[0] !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL short_coins: got count=%0d expected one 0010 eject", ejectLog.size());
        end
        compared++;
        if (doneSeen !== 1'b1 || lastShort !== 8'd1 || lastFault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL short_status: got done=%b short=%0d fault=%b expected 1/1/0",
                     doneSeen, lastShort, lastFault);
        end
    endtask

    task automatic test_timeout();
        payout(8'd40, 4'b0000, 1'b0, -1);
        compared++;
        if (ejectLog.size() != 1 || ejectLog[0] !== 4'b1000 || maxRun != 16) begin
            mismatched++;
            $display("[TB] FAIL tmo_eject: got count=%0d held=%0d expected one 1000 held 16",
                     ejectLog.size(), maxRun);
        end
        compared++;
        if (doneSeen !== 1'b1 || lastFault !== 1'b1 || lastShort !== 8'd40) begin
            mismatched++;
            $display("[TB] FAIL tmo_status: got done=%b fault=%b short=%0d expected 1/1/40",
                     doneSeen, lastFault, lastShort);
        end
        @(negedge clk);
        compared++;
        if (fault !== 1'b1 || busy !== 1'b0 || short_amt !== 8'd40) begin
            mismatched++;
            $display("[TB] FAIL tmo_sticky: got fault=%b busy=%b short=%0d expected 1/0/40",
                     fault, busy, short_amt);
        end
        start  = 1'b1;
        amount = 8'd0;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (fault !== 1'b0 || short_amt !== 8'd0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL tmo_clear: got fault=%b short=%0d busy=%b expected 0/0/1",
                     fault, short_amt, busy);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset_and_zero();
        tube_empty = 4'b0000;
        start      = 1'b1;
        amount     = 8'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        compared++;
        if (eject !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL rst_pre_eject: got %b expected 1000", eject);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (eject !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_async: got eject=%b busy=%b expected 0000/0", eject, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        amount = 8'd0;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_cycle1: got done=%b busy=%b expected 0/1", done, busy);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b1 || short_amt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL zero_cycle2: got done=%b short=%0d expected 1/0", done, short_amt);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_cycle3: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] exp[6];
        exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        payout(8'd37, 4'b0000, 1'b1, 5);
        compared++;
        if (ejectLog.size() != 6 || doneSeen !== 1'b1 || lastShort !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL busy_count: got count=%0d done=%b short=%0d expected 6/1/0",
                     ejectLog.size(), doneSeen, lastShort);
        end
        for (int i = 0; i < 6 && i < ejectLog.size(); i++) begin
            compared++;
            if (ejectLog[i] !== exp[i]) begin
                mismatched++;
                $display("[TB] FAIL busy_coin%0d: got %b expected %b", i, ejectLog[i], exp[i]);
            end
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL busy_after: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        start      = 1'b0;
        amount     = 8'd0;
        tube_empty = 4'b0000;
        hopper_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_greedy_37();
        test_empty_ten();
        test_shortfall();
        test_timeout();
        test_async_reset_and_zero();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
